// File: rtl/div_sequencer.sv
// div_sequencer: control stage in front of the iterative divider.
// Issues one load cycle, CYCLES step cycles, then holds the divider while
// its quotient/remainder are captured into LO/HI. Divide-by-zero requests
// are answered immediately with done+div_zero and never start the divider.
module div_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] quotient_in,
  input  logic [WIDTH-1:0] remainder_in,
  output logic [1:0]       div_select,
  output logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] divider,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Divider select codes.
  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_STEP = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  // Counter must reach CYCLES-1; one spare bit keeps CYCLES=1 legal.
  localparam int unsigned CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP,
    CAPTURE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Every output is a register; div_select is computed one state ahead so
  // that its registered value lines up with the state it belongs to.

  // State register and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= SEL_HOLD;
      dividend_q <= '0;
      divisor_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      zero_q     <= zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    zero_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op_b != '0) begin
            dividend_d = op_a;
            divisor_d  = op_b;
            busy_d     = 1'b1;
            sel_d      = SEL_LOAD;
            state_d    = LOAD;
          end else begin
            // Zero divisor: answer at once, divider and results untouched.
            done_d = 1'b1;
            zero_d = 1'b1;
          end
        end
      end

      LOAD: begin
        cnt_d   = '0;
        sel_d   = SEL_STEP;
        state_d = STEP;
      end

      STEP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          sel_d   = SEL_HOLD;
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        lo_d    = quotient_in;
        hi_d    = remainder_in;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        sel_d   = SEL_HOLD;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign div_select = sel_q;
  assign dividend   = dividend_q;
  assign divider    = divisor_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign div_zero   = zero_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
